// File: rtl/cpu_flag_pkg.sv
// Shared encodings for the CPU flag controller: flag bit positions, FLAG_OP and COND codes.
// Also holds the masked set/clear/toggle helper used by the flag-write path.
package cpu_flag_pkg;

  localparam int FLG_C = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_B = 0;

  typedef enum logic [1:0] {
    FLAG_OP_NONE = 2'b00,
    FLAG_OP_SET  = 2'b01,
    FLAG_OP_CLR  = 2'b10,
    FLAG_OP_TGL  = 2'b11
  } flag_op_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'b000,
    COND_C      = 3'b001,
    COND_NC     = 3'b010,
    COND_Z      = 3'b011,
    COND_NZ     = 3'b100,
    COND_B      = 3'b101,
    COND_NB     = 3'b110,
    COND_C_NZ   = 3'b111
  } cond_e;

  function automatic logic [2:0] apply_flag_op(input logic [2:0] flags,
                                               input flag_op_e op,
                                               input logic [2:0] mask);
    logic [2:0] res;
    res = flags;
    case (op)
      FLAG_OP_SET: res = flags | mask;
      FLAG_OP_CLR: res = flags & ~mask;
      FLAG_OP_TGL: res = flags ^ mask;
      default:     res = flags;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_flag_ctrl_if.sv
// Request/status bundle between decoder/ALU and the flag controller.
// ERR_CLR exists only when CPU_FLAG_ERRCLR_EN is defined.
interface cpu_flag_ctrl_if #(
  parameter int DEPTH_W = 3
);
  logic               ALU_WE;
  logic               ALU_C;
  logic               ALU_Z;
  logic               ALU_B;
  logic [1:0]         FLAG_OP;
  logic [2:0]         FLAG_MASK;
  logic               PUSH;
  logic               POP;
  logic [2:0]         COND;
  logic               C;
  logic               Z;
  logic               B;
  logic               TAKEN;
  logic [DEPTH_W-1:0] DEPTH;
  logic               OVF;
  logic               UNF;
`ifdef CPU_FLAG_ERRCLR_EN
  logic               ERR_CLR;
`endif

  modport master (
`ifdef CPU_FLAG_ERRCLR_EN
    output ERR_CLR,
`endif
    output ALU_WE, ALU_C, ALU_Z, ALU_B, FLAG_OP, FLAG_MASK, PUSH, POP, COND,
    input  C, Z, B, TAKEN, DEPTH, OVF, UNF
  );

  modport slave (
`ifdef CPU_FLAG_ERRCLR_EN
    input  ERR_CLR,
`endif
    input  ALU_WE, ALU_C, ALU_Z, ALU_B, FLAG_OP, FLAG_MASK, PUSH, POP, COND,
    output C, Z, B, TAKEN, DEPTH, OVF, UNF
  );

endinterface

// File: rtl/cpu_flag_stack.sv
// LIFO of flag entries with push, pop and in-place swap of the top entry; one-cycle update.
// No backpressure: push when full and pop when empty are ignored here, callers flag the error.
module cpu_flag_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = 3,
  parameter int ENTRY_W     = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               push,
  input  logic               pop,
  input  logic               swap,
  input  logic [ENTRY_W-1:0] wr_dat,
  output logic [ENTRY_W-1:0] top_dat,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ENTRY_W-1:0] mem [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] top_ptr;
  logic [AW-1:0]      top_idx;
  logic [AW-1:0]      push_idx;

  assign top_ptr  = depth_q - DEPTH_W'(1);
  assign top_idx  = top_ptr[AW-1:0];
  assign push_idx = depth_q[AW-1:0];
  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign depth    = depth_q;
  assign top_dat  = empty ? '0 : mem[top_idx];

  always_ff @(posedge CLK) begin
    if (RST) begin
      depth_q <= '0;
    end else if (!swap) begin
      if (push && !full) begin
        depth_q <= depth_q + DEPTH_W'(1);
      end else if (pop && !empty) begin
        depth_q <= depth_q - DEPTH_W'(1);
      end
    end
  end

  // Entries carry no reset; only slots below depth_q are ever read.
  always_ff @(posedge CLK) begin
    if (swap && !empty) begin
      mem[top_idx] <= wr_dat;
    end else if (push && !full) begin
      mem[push_idx] <= wr_dat;
    end
  end

endmodule

// File: rtl/cpu_flag_ctrl.sv
// CPU C/Z/B flag owner: POP > FLAG_OP > ALU write priority, interrupt flag stack, branch decode.
// Flags update one cycle after request; no backpressure. CPU_FLAG_ERRCLR_EN adds ERR_CLR for OVF/UNF.
module cpu_flag_ctrl
  import cpu_flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = 3
) (
  input logic           CLK,
  input logic           RST,
  cpu_flag_ctrl_if.slave bus
);

  logic [2:0]         flags_q;
  logic [2:0]         flags_d;
  logic [2:0]         alu_flags;
  logic [2:0]         stk_top;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full;
  logic               stk_empty;
  logic               do_push;
  logic               do_pop;
  logic               do_swap;
  logic               ovf_set;
  logic               unf_set;
  logic               ovf_q;
  logic               unf_q;
  logic               taken;
  flag_op_e           op;

  assign alu_flags[FLG_C] = bus.ALU_C;
  assign alu_flags[FLG_Z] = bus.ALU_Z;
  assign alu_flags[FLG_B] = bus.ALU_B;
  assign op               = flag_op_e'(bus.FLAG_OP);

  // PUSH+POP on an empty stack is a pure underflow: neither operation happens.
  always_comb begin
    do_swap = bus.PUSH & bus.POP & ~stk_empty;
    do_pop  = bus.POP & ~bus.PUSH & ~stk_empty;
    do_push = bus.PUSH & ~bus.POP & ~stk_full;
    ovf_set = bus.PUSH & ~bus.POP & stk_full;
    unf_set = bus.POP & stk_empty;
  end

  always_comb begin
    flags_d = flags_q;
    if (do_swap || do_pop) begin
      flags_d = stk_top;
    end else if (op != FLAG_OP_NONE) begin
      flags_d = apply_flag_op(flags_q, op, bus.FLAG_MASK);
    end else if (bus.ALU_WE) begin
      flags_d = alu_flags;
    end
  end

  cpu_flag_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W),
    .ENTRY_W     (3)
  ) u_stack (
    .CLK     (CLK),
    .RST     (RST),
    .push    (do_push),
    .pop     (do_pop),
    .swap    (do_swap),
    .wr_dat  (flags_q),
    .top_dat (stk_top),
    .depth   (stk_depth),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= 3'b000;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
`ifdef CPU_FLAG_ERRCLR_EN
      // A new error in the clearing cycle keeps the sticky bit set.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.ERR_CLR) begin
        ovf_q <= 1'b0;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end else if (bus.ERR_CLR) begin
        unf_q <= 1'b0;
      end
`else
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    taken = 1'b0;
    case (cond_e'(bus.COND))
      COND_ALWAYS: taken = 1'b1;
      COND_C:      taken = flags_q[FLG_C];
      COND_NC:     taken = ~flags_q[FLG_C];
      COND_Z:      taken = flags_q[FLG_Z];
      COND_NZ:     taken = ~flags_q[FLG_Z];
      COND_B:      taken = flags_q[FLG_B];
      COND_NB:     taken = ~flags_q[FLG_B];
      COND_C_NZ:   taken = flags_q[FLG_C] & ~flags_q[FLG_Z];
      default:     taken = 1'b0;
    endcase
  end

  assign bus.C     = flags_q[FLG_C];
  assign bus.Z     = flags_q[FLG_Z];
  assign bus.B     = flags_q[FLG_B];
  assign bus.TAKEN = taken;
  assign bus.DEPTH = stk_depth;
  assign bus.OVF   = ovf_q;
  assign bus.UNF   = unf_q;

endmodule
